param_seq_alu: RTL
==================

PARAM_SEQ_ALU -- requirements
Module: param_seq_alu

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width; legal values: powers of two, 4..32.
REQ-002 SHALL provide ports: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL provide: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide: in_valid  input  1  operation request; in_ready  output  1  request accepted when both high.
REQ-005 SHALL provide: a, b  input  WIDTH each  operands; opcode  input  3  operation select.
REQ-006 SHALL provide: out_valid  output  1  result available; out_ready  input  1  result consumed when both high.
REQ-007 SHALL provide: result  output  WIDTH  low result; result_hi  output  WIDTH  product high half, else 0.
REQ-008 SHALL provide flags, each output 1 bit: carry, zero, negative, overflow, illegal.

Function
REQ-009 SHALL decode opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr (logical), 111 mul (unsigned).
REQ-010 SHALL use states IDLE, EXEC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-011 SHALL register a, b, opcode on acceptance; later input changes have no effect on the accepted operation.
REQ-012 Non-mul ops: IDLE -> DONE on acceptance; out_valid high the cycle after acceptance (latency 1).
REQ-013 Mul: IDLE -> EXEC; shift-add, one bit per cycle, WIDTH cycles; EXEC -> DONE; out_valid high WIDTH+1 cycles after acceptance.
REQ-014 DONE -> IDLE on out_valid && out_ready; result and flags SHALL hold stable while out_valid && !out_ready.
REQ-015 in_valid SHALL be ignored outside IDLE; no new operation can overlap or precede handshake completion.
REQ-016 add: {carry,result} = a+b, WIDTH+1 bits; overflow = signed overflow (operand signs equal, result sign differs).
REQ-017 sub: result = a-b mod 2^WIDTH; carry = borrow (a < b unsigned); overflow = signed overflow.
REQ-018 and/or/xor: bitwise; carry = 0, overflow = 0.
REQ-019 shl/shr: shift a by b[log2(WIDTH)-1:0], zero fill; carry = 0, overflow = 0.
REQ-020 mul: {result_hi,result} = a*b, full 2*WIDTH bits; carry = 0, overflow = 0.
REQ-021 zero SHALL be 1 iff result == 0 (non-mul) or {result_hi,result} == 0 (mul).
REQ-022 negative SHALL be result[WIDTH-1] for non-mul, result_hi[WIDTH-1] for mul.
REQ-023 result_hi SHALL be 0 for every non-mul op; illegal SHALL be 0 for every legal op.

Reset
REQ-024 rst high at a clock edge SHALL force IDLE; result, result_hi, all flags, out_valid = 0; in_ready = 1 the following cycle.
REQ-025 rst during EXEC or DONE SHALL abort the operation with no result ever presented for it.
REQ-026 rst SHALL take priority over a simultaneous in_valid or out_ready handshake.

Configuration
REQ-027 SHALL compile multiply support only when macro PARAM_SEQ_ALU_MUL_EN is defined.
REQ-028 With PARAM_SEQ_ALU_MUL_EN defined: opcode 111 behaves per REQ-013/REQ-020; EXEC state and shift-add datapath present.
REQ-029 Without it: no EXEC state or multiplier logic; opcode 111 completes with latency 1, result = 0, result_hi = 0, all other flags 0, illegal = 1.

Verification (WIDTH = 8, macro defined unless stated)
REQ-030 add a=0x7F b=0x01 -> one cycle later out_valid=1, result=0x80, overflow=1, negative=1, carry=0, zero=0.
REQ-031 sub a=0x00 b=0x01 -> result=0xFF, carry=1, negative=1, overflow=0; add a=0xFF b=0x01 -> result=0x00, carry=1, zero=1.
REQ-032 mul a=0xFF b=0xFF -> in_ready=0 during EXEC; out_valid 9 cycles after acceptance; result_hi=0xFE, result=0x01, negative=1.
REQ-033 xor a=0xA5 b=0xA5, out_ready=0 for 5 cycles -> result=0x00, zero=1 held stable; in_ready=0; in_valid pulses ignored; IDLE one cycle after out_ready=1.
REQ-034 rst pulsed on 4th EXEC cycle of mul 0x12*0x34 -> next cycle out_valid=0, in_ready=1, result=0, result_hi=0; no result ever emitted.
REQ-035 Macro undefined, opcode=111 a=0x03 b=0x04 -> one cycle later out_valid=1, illegal=1, result=0x00, result_hi=0x00.

Source files
------------

// File: rtl/param_seq_alu.sv
// Sequential ALU with a valid/ready request side and a valid/ready result side.
// Multiply (opcode 111, shift-add) is built only when PARAM_SEQ_ALU_MUL_EN is defined.
module param_seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             illegal,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and results hold while unaccepted.
  localparam int SW = $clog2(WIDTH);

`ifdef PARAM_SEQ_ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_n;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SW-1:0]      cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic             carry_q, carry_d, zero_q, zero_d, negative_q, negative_d;
  logic             overflow_q, overflow_d, illegal_q, illegal_d;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;

  // Single-cycle operations evaluated straight from the inputs at acceptance.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    case (opcode)
      3'b000: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010:  alu_res = a & b;
      3'b011:  alu_res = a | b;
      3'b100:  alu_res = a ^ b;
      3'b101:  alu_res = a << b[SW-1:0];
      3'b110:  alu_res = a >> b[SW-1:0];
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;
`ifdef PARAM_SEQ_ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_n    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef PARAM_SEQ_ALU_MUL_EN
          if (opcode == 3'b111) begin
            state_d  = EXEC;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
          end else
`endif
          begin
            state_d     = DONE;
            result_d    = alu_res;
            result_hi_d = '0;
            carry_d     = alu_c;
            zero_d      = (alu_res == '0) && !alu_ill;
            negative_d  = alu_res[WIDTH-1];
            overflow_d  = alu_v;
            illegal_d   = alu_ill;
          end
        end
      end
`ifdef PARAM_SEQ_ALU_MUL_EN
      EXEC: begin
        acc_d    = acc_n;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          result_d    = acc_n[WIDTH-1:0];
          result_hi_d = acc_n[2*WIDTH-1:WIDTH];
          carry_d     = 1'b0;
          zero_d      = (acc_n == '0);
          negative_d  = acc_n[2*WIDTH-1];
          overflow_d  = 1'b0;
          illegal_d   = 1'b0;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef PARAM_SEQ_ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
`ifdef PARAM_SEQ_ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;
  assign state_dbg = state_q;

endmodule
